// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the ram32x4 command sequencer.
// Op encoding matches the host-facing cmd_op field.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_W    = 5;
    localparam int RAM_DATA_W    = 4;
    localparam int RAM_LAST_ADDR = 31;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_SCAN  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_CAPT,
        ST_RSP_HOLD,
        ST_FILL
    } state_t;

endpackage

// File: rtl/ram32x4_ctrl.sv
// Single-port sequencer for ram32x4: READ/WRITE/FILL/SCAN commands in,
// registered RAM cycles out, read words on a valid/ready response channel.
module ram32x4_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_n;
    op_t               op_q, op_n;
    logic [ADDR_W-1:0] mem_address_n, rsp_addr_n;
    logic [DATA_W-1:0] mem_data_n, rsp_data_n;
    logic              mem_wren_n, rsp_valid_n, rsp_last_n, done_n;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            op_q        <= OP_READ;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
            rsp_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            mem_address <= mem_address_n;
            mem_data    <= mem_data_n;
            mem_wren    <= mem_wren_n;
            rsp_valid   <= rsp_valid_n;
            rsp_addr    <= rsp_addr_n;
            rsp_data    <= rsp_data_n;
            rsp_last    <= rsp_last_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        op_n          = op_q;
        mem_address_n = mem_address;
        mem_data_n    = mem_data;
        mem_wren_n    = mem_wren;
        rsp_valid_n   = rsp_valid;
        rsp_addr_n    = rsp_addr;
        rsp_data_n    = rsp_data;
        rsp_last_n    = rsp_last;
        done_n        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_n = op_t'(cmd_op);
                    case (op_t'(cmd_op))
                        OP_READ: begin
                            mem_address_n = cmd_addr;
                            state_n       = ST_RD_ISSUE;
                        end
                        OP_WRITE: begin
                            mem_address_n = cmd_addr;
                            mem_data_n    = cmd_data;
                            mem_wren_n    = 1'b1;
                            state_n       = ST_WR;
                        end
                        OP_FILL: begin
                            mem_address_n = '0;
                            mem_data_n    = cmd_data;
                            mem_wren_n    = 1'b1;
                            state_n       = ST_FILL;
                        end
                        default: begin
                            mem_address_n = '0;
                            state_n       = ST_RD_ISSUE;
                        end
                    endcase
                end
            end
            ST_WR: begin
                mem_wren_n = 1'b0;
                done_n     = 1'b1;
                state_n    = ST_IDLE;
            end
            ST_FILL: begin
                // Counter parks on the last address; it never wraps back to 0.
                if (mem_address == LAST_ADDR) begin
                    mem_wren_n = 1'b0;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    mem_address_n = mem_address + 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                state_n = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                rsp_data_n  = mem_q;
                rsp_addr_n  = mem_address;
                rsp_valid_n = 1'b1;
                rsp_last_n  = (op_q == OP_READ) || (mem_address == LAST_ADDR);
                state_n     = ST_RSP_HOLD;
            end
            ST_RSP_HOLD: begin
                // rsp_* are untouched until the consumer takes the word.
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    if (rsp_last) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        mem_address_n = mem_address + 1'b1;
                        state_n       = ST_RD_ISSUE;
                    end
                end
            end
            default: begin
                mem_wren_n = 1'b0;
                state_n    = ST_IDLE;
            end
        endcase
    end

endmodule
